idma_backend_req_rr_scheduler: RTL and testbench

// - Shares one iDMA 1D backend (e.g. AXI-read/OBI-write variant) between NumReq frontends.
// - Round-robin arbitrates 1D requests onto the backend request port.
// - Records the owner of each accepted request in an in-order tag FIFO.
// - Routes each backend response to its owner; the backend returns one response per request, in issue order.

---
 rtl/idma_backend_req_rr_scheduler_pkg.sv | 28 ++
 rtl/idma_backend_req_rr_scheduler_tag_fifo.sv | 68 ++++++
 rtl/idma_backend_req_rr_scheduler.sv | 113 +++++++++++
 tb/tb_idma_backend_req_rr_scheduler.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_backend_req_rr_scheduler_pkg.sv
// Shared types for the iDMA backend request scheduler: default 1D request/response
// payloads and a small index-wrap helper for the round-robin search.
package idma_backend_req_rr_scheduler_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned LenWidth  = 32;
  localparam int unsigned OptWidth  = 8;
  localparam int unsigned PldWidth  = 32;

  typedef struct packed {
    logic [LenWidth-1:0]  length;
    logic [AddrWidth-1:0] src_addr;
    logic [AddrWidth-1:0] dst_addr;
    logic [OptWidth-1:0]  opt;
  } idma_req_t;

  typedef struct packed {
    logic                last;
    logic                error;
    logic [PldWidth-1:0] pld;
  } idma_rsp_t;

  // Inputs are always below 2*n, so a single conditional subtract wraps them.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/idma_backend_req_rr_scheduler_tag_fifo.sv
// In-order owner tag FIFO (registered output, no fall-through).
// Push is ignored when full and pop when empty.
module idma_backend_req_rr_scheduler_tag_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;

  logic [Width-1:0]    mem_q [Depth];
  ptr_t                wr_ptr_q, wr_ptr_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/idma_backend_req_rr_scheduler.sv
// Shares one iDMA 1D backend between NumReq frontends: round-robin request grant with
// a lock while the backend stalls, and in-order response routing via an owner tag FIFO.
module idma_backend_req_rr_scheduler
  import idma_backend_req_rr_scheduler_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned NumInflight = 8,
  parameter type         req_t       = idma_req_t,
  parameter type         rsp_t       = idma_rsp_t,
  localparam int unsigned IdxWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  input  req_t [NumReq-1:0] req_i,
  output logic [NumReq-1:0] rsp_valid_o,
  input  logic [NumReq-1:0] rsp_ready_i,
  output rsp_t              rsp_o,
  output logic              be_req_valid_o,
  input  logic              be_req_ready_i,
  output req_t              be_req_o,
  input  logic              be_rsp_valid_i,
  output logic              be_rsp_ready_o,
  input  rsp_t              be_rsp_i,
  output logic              busy_o
);

  typedef logic [IdxWidth-1:0] idx_t;

  idx_t        ptr_q, ptr_d;
  idx_t        sel_q, sel_d;
  logic        lock_q, lock_d;
  idx_t        sel, cand_idx, head;
  logic        cand_found, offer;
  logic        fifo_full, fifo_empty;
  logic        req_hs, rsp_hs;
  int unsigned idx;

  // Grant side: fifo_full is registered, so responses never reach the grant path.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = ptr_q;
    idx        = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = rr_wrap(32'(ptr_q) + k, NumReq);
      if (!cand_found && req_valid_i[idx_t'(idx)]) begin
        cand_found = 1'b1;
        cand_idx   = idx_t'(idx);
      end
    end

    offer          = lock_q ? req_valid_i[sel_q] : cand_found;
    sel            = lock_q ? sel_q : cand_idx;
    be_req_valid_o = rst_ni && offer && !fifo_full;
    be_req_o       = req_i[sel];
    req_hs         = be_req_valid_o && be_req_ready_i;

    req_ready_o = '0;
    if (req_hs) req_ready_o[sel] = 1'b1;

    lock_d = be_req_valid_o && !be_req_ready_i;
    sel_d  = lock_d ? sel : sel_q;
    ptr_d  = req_hs ? idx_t'(rr_wrap(32'(sel) + 1, NumReq)) : ptr_q;
  end

  always_comb begin
    rsp_valid_o    = '0;
    be_rsp_ready_o = 1'b0;
    if (rst_ni && !fifo_empty) begin
      rsp_valid_o[head] = be_rsp_valid_i;
      be_rsp_ready_o    = rsp_ready_i[head];
    end
    rsp_hs = be_rsp_valid_i && be_rsp_ready_o;
  end

  assign rsp_o  = be_rsp_i;
  assign busy_o = !fifo_empty || be_req_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      lock_q <= lock_d;
    end
  end

  idma_backend_req_rr_scheduler_tag_fifo #(
    .Depth (NumInflight),
    .Width (IdxWidth)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_hs),
    .data_i  (sel),
    .pop_i   (rsp_hs),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifndef SYNTHESIS
  a_lock_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[sel_q]);
  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    be_rsp_valid_i |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_idma_backend_req_rr_scheduler.sv
// Self-checking bench for idma_backend_req_rr_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_idma_backend_req_rr_scheduler;
  import idma_backend_req_rr_scheduler_pkg::*;

  localparam int N    = 4;
  localparam int INFL = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  idma_req_t [N-1:0] req_i;
  idma_rsp_t       rsp_o, be_rsp_i;
  idma_req_t       be_req_o;
  logic            be_req_valid_o, be_req_ready_i, be_rsp_valid_i, be_rsp_ready_o, busy_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int      m_ptr;
  bit      m_lock;
  int      m_lock_sel;
  int      m_q[$];
  int      e_sel;
  logic    e_be_valid, e_be_rsp_ready, e_busy;
  logic [N-1:0] e_req_ready, e_rsp_valid;

  always #5 clk_i = ~clk_i;

  idma_backend_req_rr_scheduler #(
    .NumReq      (N),
    .NumInflight (INFL),
    .req_t       (idma_req_t),
    .rsp_t       (idma_rsp_t)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_i          (req_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_o          (rsp_o),
    .be_req_valid_o (be_req_valid_o),
    .be_req_ready_i (be_req_ready_i),
    .be_req_o       (be_req_o),
    .be_rsp_valid_i (be_rsp_valid_i),
    .be_rsp_ready_o (be_rsp_ready_o),
    .be_rsp_i       (be_rsp_i),
    .busy_o         (busy_o)
  );

  function automatic idma_req_t rand_req();
    idma_req_t r;
    r.length   = $urandom;
    r.src_addr = $urandom;
    r.dst_addr = $urandom;
    r.opt      = 8'($urandom);
    return r;
  endfunction

  function automatic idma_rsp_t rand_rsp();
    idma_rsp_t r;
    r.last  = 1'($urandom);
    r.error = 1'($urandom);
    r.pld   = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    m_lock = 0;
    m_lock_sel = 0;
    m_q.delete();
  endfunction

  // Expected outputs: oldest-owner routing from the queue, next requester after the
  // last grant, held choice while the backend stalls.
  function automatic void model_eval();
    bit full;
    e_sel = -1;
    if (m_lock) e_sel = m_lock_sel;
    else
      for (int k = 0; k < N; k++)
        if (e_sel < 0 && req_valid_i[(m_ptr + k) % N]) e_sel = (m_ptr + k) % N;
    full = (m_q.size() == INFL);
    e_be_valid = rst_ni && (e_sel >= 0) && !full;
    e_req_ready = '0;
    if (e_be_valid && be_req_ready_i) e_req_ready[e_sel] = 1'b1;
    e_rsp_valid = '0;
    e_be_rsp_ready = 1'b0;
    if (rst_ni && m_q.size() > 0) begin
      e_rsp_valid[m_q[0]] = be_rsp_valid_i;
      e_be_rsp_ready = rsp_ready_i[m_q[0]];
    end
    e_busy = (m_q.size() > 0) || e_be_valid;
  endfunction

  task automatic tick();
    bit push, pop, lk;
    int s;
    model_eval();
    push = e_be_valid && be_req_ready_i;
    pop  = be_rsp_valid_i && e_be_rsp_ready;
    lk   = e_be_valid && !be_req_ready_i;
    s    = e_sel;
    @(posedge clk_i);
    if (rst_ni) begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(s);
        m_ptr = (s + 1) % N;
      end
      m_lock = lk;
      if (lk) m_lock_sel = s;
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    req_valid_i    = '0;
    be_req_ready_i = 1'b0;
    be_rsp_valid_i = 1'b0;
    rsp_ready_i    = '0;
  endtask

  task automatic fill();
    req_valid_i = '1;
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b0;
    for (int c = 0; c < INFL; c++) begin
      for (int i = 0; i < N; i++) req_i[i] = rand_req();
      tick();
    end
    req_valid_i = '0;
  endtask

  task automatic drain();
    req_valid_i = '0;
    rsp_ready_i = '1;
    for (int k = 0; k < INFL + 2; k++) begin
      if (m_q.size() == 0) break;
      be_rsp_valid_i = 1'b1;
      be_rsp_i = rand_rsp();
      tick();
    end
    be_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = '1;
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    for (int i = 0; i < N; i++) req_i[i] = rand_req();
    be_rsp_i = rand_rsp();
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (be_req_valid_o !== 1'b0 || req_ready_o !== '0) begin
      failures++;
      $display("FAIL reset_req: be_req_valid=%b req_ready=%b, expected 0 and 0000", be_req_valid_o, req_ready_o);
    end
    checks++;
    if (rsp_valid_o !== '0 || be_rsp_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: rsp_valid=%b be_rsp_ready=%b, expected 0000 and 0", rsp_valid_o, be_rsp_ready_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", busy_o);
    end
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || be_rsp_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b be_rsp_ready=%b expected 0 0", busy_o, be_rsp_ready_o);
    end
    tick();
  endtask

  task automatic test_fairness();
    req_valid_i = '1;
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b0;
    rsp_ready_i = '1;
    for (int c = 0; c < INFL; c++) begin
      for (int i = 0; i < N; i++) req_i[i] = rand_req();
      #1;
      checks++;
      if (be_req_valid_o !== 1'b1 || req_ready_o !== onehot(c % N)) begin
        failures++;
        $display("FAIL fair_grant c=%0d: valid=%b req_ready=%b expected 1 %b", c, be_req_valid_o, req_ready_o, onehot(c % N));
      end
      checks++;
      if (be_req_o !== req_i[c % N]) begin
        failures++;
        $display("FAIL fair_payload c=%0d: got %h expected %h", c, be_req_o, req_i[c % N]);
      end
      tick();
    end
    #1;
    checks++;
    if (be_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL fair_full: valid=%b busy=%b expected 0 1", be_req_valid_o, busy_o);
    end
    req_valid_i = '0;
    be_rsp_valid_i = 1'b1;
    for (int c = 0; c < INFL; c++) begin
      be_rsp_i = rand_rsp();
      #1;
      checks++;
      if (rsp_valid_o !== onehot(c % N) || be_rsp_ready_o !== 1'b1 || rsp_o !== be_rsp_i) begin
        failures++;
        $display("FAIL fair_tag_order c=%0d: rsp_valid=%b ready=%b rsp=%h expected %b 1 %h", c, rsp_valid_o, be_rsp_ready_o, rsp_o, onehot(c % N), be_rsp_i);
      end
      tick();
    end
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL fair_drained: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_stall_lock();
    idma_req_t p2;
    p2 = rand_req();
    req_i[2] = p2;
    req_valid_i = 4'b0100;
    be_req_ready_i = 1'b0;
    rsp_ready_i = '1;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) begin
        req_valid_i[0] = 1'b1;
        req_i[0] = rand_req();
      end
      #1;
      checks++;
      if (be_req_valid_o !== 1'b1 || be_req_o !== p2 || req_ready_o !== '0) begin
        failures++;
        $display("FAIL lock_hold c=%0d: valid=%b payload=%h ready=%b expected 1 %h 0000", c, be_req_valid_o, be_req_o, req_ready_o, p2);
      end
      tick();
    end
    be_req_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0100 || be_req_o !== p2) begin
      failures++;
      $display("FAIL lock_grant: req_ready=%b payload=%h expected 0100 %h", req_ready_o, be_req_o, p2);
    end
    tick();
    req_valid_i[2] = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001 || be_req_o !== req_i[0]) begin
      failures++;
      $display("FAIL lock_next: req_ready=%b expected 0001", req_ready_o);
    end
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    req_valid_i = '1;
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) req_i[i] = rand_req();
      #1;
      if (be_req_valid_o === 1'b1 && req_ready_o !== '0) accepted++;
      tick();
    end
    #1;
    checks++;
    if (accepted != INFL) begin
      failures++;
      $display("FAIL bp_count: accepted %0d expected %0d", accepted, INFL);
    end
    checks++;
    if (be_req_valid_o !== 1'b0 || busy_o !== 1'b1 || req_ready_o !== '0) begin
      failures++;
      $display("FAIL bp_blocked: valid=%b busy=%b ready=%b expected 0 1 0000", be_req_valid_o, busy_o, req_ready_o);
    end
    drain();
  endtask

  task automatic test_routing();
    int owners[3] = '{3, 1, 3};
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid_i = onehot(owners[c]);
      req_i[owners[c]] = rand_req();
      #1;
      checks++;
      if (req_ready_o !== onehot(owners[c])) begin
        failures++;
        $display("FAIL route_issue c=%0d: req_ready=%b expected %b", c, req_ready_o, onehot(owners[c]));
      end
      tick();
    end
    req_valid_i = '0;
    rsp_ready_i = '1;
    be_rsp_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      be_rsp_i = rand_rsp();
      #1;
      checks++;
      if (rsp_valid_o !== onehot(owners[c]) || rsp_o !== be_rsp_i || be_rsp_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL route_rsp c=%0d: rsp_valid=%b rsp=%h ready=%b expected %b %h 1", c, rsp_valid_o, rsp_o, be_rsp_ready_o, onehot(owners[c]), be_rsp_i);
      end
      tick();
    end
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL route_empty: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_rsp_stall();
    be_req_ready_i = 1'b1;
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = '0;
    be_rsp_valid_i = 1'b1;
    rsp_ready_i = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      be_rsp_i = rand_rsp();
      #1;
      checks++;
      if (be_rsp_ready_o !== 1'b0 || rsp_valid_o !== 4'b0010 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL rsp_stall c=%0d: ready=%b rsp_valid=%b busy=%b expected 0 0010 1", c, be_rsp_ready_o, rsp_valid_o, busy_o);
      end
      tick();
    end
    rsp_ready_i = '1;
    #1;
    checks++;
    if (be_rsp_ready_o !== 1'b1 || rsp_valid_o !== 4'b0010) begin
      failures++;
      $display("FAIL rsp_release: ready=%b rsp_valid=%b expected 1 0010", be_rsp_ready_o, rsp_valid_o);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid_o !== 4'b0100) begin
      failures++;
      $display("FAIL rsp_next_owner: rsp_valid=%b expected 0100", rsp_valid_o);
    end
    tick();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rsp_stall_empty: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_full_simul();
    fill();
    req_valid_i = 4'b0001;
    req_i[0] = rand_req();
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    be_rsp_i = rand_rsp();
    #1;
    checks++;
    if (be_req_valid_o !== 1'b0 || req_ready_o !== '0 || be_rsp_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_cycle: valid=%b req_ready=%b rsp_ready=%b expected 0 0000 1", be_req_valid_o, req_ready_o, be_rsp_ready_o);
    end
    tick();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (be_req_valid_o !== 1'b1 || req_ready_o !== 4'b0001) begin
      failures++;
      $display("FAIL full_next_grant: valid=%b req_ready=%b expected 1 0001", be_req_valid_o, req_ready_o);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    req_valid_i = '1;
    be_req_ready_i = 1'b1;
    rsp_ready_i = '1;
    repeat (3) tick();
    be_rsp_valid_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (be_req_valid_o !== 1'b0 || req_ready_o !== '0 || rsp_valid_o !== '0 ||
        be_rsp_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async: breq=%b rready=%b rsp_valid=%b bready=%b busy=%b expected all 0",
               be_req_valid_o, req_ready_o, rsp_valid_o, be_rsp_ready_o, busy_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b1;
    model_reset();
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_empty: busy=%b expected 0", busy_o);
    end
    req_valid_i = 4'b1010;
    be_req_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0010) begin
      failures++;
      $display("FAIL mid_reset_ptr: req_ready=%b expected 0010", req_ready_o);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_lock && i == m_lock_sel) req_valid_i[i] = 1'b1;
        else begin
          req_valid_i[i] = ($urandom_range(0, 1) == 1);
          req_i[i] = rand_req();
        end
        rsp_ready_i[i] = ($urandom_range(0, 9) < 7);
      end
      be_req_ready_i = ($urandom_range(0, 9) < 6);
      be_rsp_valid_i = (m_q.size() > 0) && ($urandom_range(0, 9) < 5);
      be_rsp_i = rand_rsp();
      #1;
      model_eval();
      checks++;
      if (be_req_valid_o !== e_be_valid || req_ready_o !== e_req_ready) begin
        failures++;
        $display("FAIL rand_grant c=%0d: valid=%b req_ready=%b expected %b %b", c, be_req_valid_o, req_ready_o, e_be_valid, e_req_ready);
      end
      if (e_be_valid) begin
        checks++;
        if (be_req_o !== req_i[e_sel]) begin
          failures++;
          $display("FAIL rand_payload c=%0d: got %h expected %h", c, be_req_o, req_i[e_sel]);
        end
      end
      checks++;
      if (rsp_valid_o !== e_rsp_valid || be_rsp_ready_o !== e_be_rsp_ready || rsp_o !== be_rsp_i) begin
        failures++;
        $display("FAIL rand_route c=%0d: rsp_valid=%b ready=%b expected %b %b", c, rsp_valid_o, be_rsp_ready_o, e_rsp_valid, e_be_rsp_ready);
      end
      checks++;
      if (busy_o !== e_busy) begin
        failures++;
        $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy_o, e_busy);
      end
      tick();
    end
    if (m_lock) begin
      be_req_ready_i = 1'b1;
      tick();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    be_rsp_i = '0;
    req_i = '0;
    test_reset();
    test_fairness();
    test_stall_lock();
    test_backpressure();
    test_routing();
    test_rsp_stall();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
